// File: rtl/parallel_master.sv
// parallel_master: initiator of the 8-bit Pi/DE0-Nano parallel link; sends one axis
// command byte, turns the bus around and reads back a 16-bit sample, low byte first.
module parallel_master #(
    parameter int HALF_PERIOD = 25,
    parameter int CMD_BASE    = 120
) (
    input  logic        CLK_50,
    input  logic        iRSTN,
    input  logic        start,
    input  logic [1:0]  axis,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] result,
    output logic        RP_clock,
    output logic        RP_CS,
    inout  wire  [7:0]  RP_data
);
    // One state per bus half-phase; the timed states run in enum order.
    typedef enum logic [3:0] {
        IDLE, SETUP, CMD_LO, CMD_HI, TURN, RD_LO, GAP, RD_HI, HOLD, DONE
    } state_t;
    state_t state, state_n;
    logic [9:0] cnt, last;
    logic [1:0] axis_q;
    logic [7:0] lo_byte, hi_byte, cmd;
    logic       oe, at_end, idle, accept;
    // Turnaround and hold are stretched to three half-periods of guard time.
    assign last   = (state == TURN || state == HOLD) ? 10'(3 * HALF_PERIOD - 1) : 10'(HALF_PERIOD - 1);
    assign at_end = cnt == last;
    assign idle   = state == IDLE && !done;
    assign accept = idle && start && axis != 2'd3;
    assign busy   = state != IDLE || done;
    assign cmd    = 8'(CMD_BASE + int'(axis_q));
    assign RP_data = oe ? cmd : 8'hzz;
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (accept ? SETUP : IDLE) :
                  (state == DONE) ? IDLE :
                  at_end          ? state_t'(state + 4'd1) : state;
    end
    always_ff @(posedge CLK_50) begin
        if (!iRSTN) begin
            state    <= IDLE;
            cnt      <= '0;
            axis_q   <= '0;
            lo_byte  <= '0;
            hi_byte  <= '0;
            result   <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            RP_clock <= 1'b0;
            RP_CS    <= 1'b1;
            oe       <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= (state_n != state || state == IDLE) ? '0 : cnt + 10'd1;
            done     <= state == DONE;
            error    <= idle && start && axis == 2'd3;
            if (accept) axis_q <= axis;
            if (state == RD_LO && at_end) lo_byte <= RP_data;
            if (state == RD_HI && at_end) hi_byte <= RP_data;
            if (state == DONE) result <= {hi_byte, lo_byte};
            RP_clock <= state_n == CMD_HI || state_n == RD_LO || state_n == RD_HI;
            RP_CS    <= state_n == IDLE || state_n == DONE;
            oe       <= state_n == CMD_LO || state_n == CMD_HI;
        end
    end
endmodule

// File: tb/tb_parallel_master.sv
// tb_parallel_master: two masters (HALF_PERIOD 25 and 2) each talking to a behavioural
// responder; transactions are checked against expected command, result, latency and framing.
module tb_parallel_master;
    logic        clk = 1'b0, rstn = 1'b0, mon = 1'b0;
    logic        start [2], busy [2], done [2], error [2], rpc [2], rpcs [2], r_oe [2];
    logic [1:0]  ax [2];
    logic [15:0] res [2];
    logic [7:0]  r_val [2], r_lo [2], r_hi [2], cmd_seen [2];
    int          edges [2], last_edges [2], cs_falls [2];
    int          checks = 0, failures = 0;
    wire  [7:0]  bus0, bus1;

    always #10 clk = ~clk;

    pullup (bus0);
    pullup (bus1);
    assign bus0 = r_oe[0] ? r_val[0] : 8'hzz;
    assign bus1 = r_oe[1] ? r_val[1] : 8'hzz;

    parallel_master #(.HALF_PERIOD(25)) dut0 (
        .CLK_50(clk), .iRSTN(rstn), .start(start[0]), .axis(ax[0]), .busy(busy[0]),
        .done(done[0]), .error(error[0]), .result(res[0]), .RP_clock(rpc[0]),
        .RP_CS(rpcs[0]), .RP_data(bus0));
    parallel_master #(.HALF_PERIOD(2)) dut1 (
        .CLK_50(clk), .iRSTN(rstn), .start(start[1]), .axis(ax[1]), .busy(busy[1]),
        .done(done[1]), .error(error[1]), .result(res[1]), .RP_clock(rpc[1]),
        .RP_CS(rpcs[1]), .RP_data(bus1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] busv(input int u);
        return u != 0 ? bus1 : bus0;
    endfunction

    // Responder: captures the command on rising edge 1, presents lo on edge 2 and hi on edge 3.
    for (genvar g = 0; g < 2; g++) begin : resp
        initial begin
            r_oe[g] = 1'b0;
            edges[g] = 0;
        end
        always @(posedge rpc[g] or posedge rpcs[g]) begin
            if (rpcs[g]) begin
                r_oe[g] = 1'b0;
                last_edges[g] = edges[g];
                edges[g] = 0;
            end else begin
                edges[g]++;
                if (edges[g] == 1) cmd_seen[g] = busv(g);
                else begin
                    if (edges[g] == 2) check("turnaround_z", busv(g), 8'hff);
                    r_val[g] = edges[g] == 2 ? r_lo[g] : r_hi[g];
                    r_oe[g] = 1'b1;
                end
            end
        end
        always @(negedge rpcs[g]) cs_falls[g]++;
        always @(negedge clk) if (mon) begin
            if (r_oe[g]) check("contention", busv(g), r_val[g]);
            else if (rpcs[g]) check("idle_z", busv(g), 8'hff);
        end
    end

    task automatic run_txn(input int u, input logic [1:0] a, input logic [7:0] lo,
                           input logic [7:0] hi, input bit spam);
        int hp = u != 0 ? 2 : 25;
        int n = 1;
        int falls0 = cs_falls[u];
        logic [15:0] prev = res[u];
        r_lo[u] = lo;
        r_hi[u] = hi;
        @(negedge clk);
        start[u] = 1'b1;
        ax[u] = a;
        @(posedge clk); #1;
        start[u] = spam;
        if (a == 2'd3) begin
            start[u] = 1'b0;
            check("err_pulse", error[u], 1);
            check("err_busy", busy[u], 0);
            check("err_cs", rpcs[u], 1);
            @(posedge clk); #1;
            check("err_once", error[u], 0);
            check("err_result", res[u], prev);
            check("err_no_txn", cs_falls[u] - falls0, 0);
            return;
        end
        check("busy_on", busy[u], 1);
        while (!done[u] && n < 12 * hp + 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 12 * hp + 2);
        check("done_busy", busy[u], 1);
        check("result", res[u], {hi, lo});
        check("cmd_byte", cmd_seen[u], 8'(120 + int'(a)));
        check("rise_edges", last_edges[u], 3);
        @(posedge clk); #1;
        start[u] = 1'b0;
        check("done_width", done[u], 0);
        check("idle_after", busy[u], 0);
        check("one_txn", cs_falls[u] - falls0, 1);
    endtask

    task automatic reset_mid(input int u);
        int n = 0;
        int dn = 0;
        r_lo[u] = 8'h5a;
        r_hi[u] = 8'ha5;
        @(negedge clk);
        start[u] = 1'b1;
        ax[u] = 2'd1;
        @(posedge clk); #1;
        start[u] = 1'b0;
        while (edges[u] != 2 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_rd_lo", edges[u], 2);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("rst_cs", rpcs[u], 1);
        check("rst_clk", rpc[u], 0);
        check("rst_bus", busv(u), 8'hff);
        check("rst_busy", busy[u], 0);
        check("rst_result", res[u], 0);
        rstn = 1'b1;
        repeat (400) begin
            @(posedge clk); #1;
            if (done[u]) dn++;
        end
        check("rst_no_done", dn, 0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0;
            ax[u] = 2'd0;
            r_lo[u] = 8'h00;
            r_hi[u] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("reset_cs", rpcs[u], 1);
            check("reset_clk", rpc[u], 0);
            check("reset_bus", busv(u), 8'hff);
            check("reset_busy", busy[u], 0);
            check("reset_done", done[u], 0);
            check("reset_result", res[u], 0);
        end
        rstn = 1'b1;
        mon = 1'b1;
        run_txn(0, 2'd1, 8'h34, 8'h12, 1'b0);
        run_txn(0, 2'd3, 8'h00, 8'h00, 1'b0);
        run_txn(0, 2'd0, 8'($urandom), 8'($urandom), 1'b1);
        reset_mid(0);
        run_txn(0, 2'd2, 8'($urandom), 8'($urandom), 1'b0);
        for (int i = 0; i < 30; i++)
            run_txn(1, 2'($urandom_range(3)), 8'($urandom), 8'($urandom), 1'($urandom_range(1)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
